// File: rtl/fir_settle_monitor.sv
// fir_settle_monitor: step-response settle-time monitor for FIR output; `FIR_SETTLE_PEAK_EN builds the peak tracker
module fir_settle_monitor #(
  parameter int DATA_W  = 14,
  parameter int TOL     = 16,
  parameter int HOLD    = 8,
  parameter int MAX_CNT = 1000,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clk_enable,
  input  logic                     start,
  input  logic signed [DATA_W-1:0] target,
  input  logic signed [DATA_W-1:0] sample_in,
  output logic                     busy,
  output logic                     done,
  output logic                     settled,
  output logic                     timeout,
  output logic [CNT_W-1:0]         settle_count,
  output logic signed [DATA_W-1:0] peak
);
  localparam int RUN_W = $clog2(HOLD + 1);
  localparam logic signed [DATA_W:0] TOL_S = (DATA_W + 1)'(TOL);
  typedef enum logic [1:0] {IDLE, TRACK, DONE} state_t;
  state_t                   r_state;
  logic signed [DATA_W-1:0] r_target;
  logic [CNT_W-1:0]         r_cnt;
  logic [RUN_W-1:0]         r_run;
  logic                     r_busy, r_done, r_settled, r_timeout;
  logic [CNT_W-1:0]         r_settle_count;
  logic signed [DATA_W:0]   w_err;
  logic                     w_in_band, w_settle, w_last;
  // one extra bit keeps the difference of two full-range samples exact
  assign w_err     = {sample_in[DATA_W-1], sample_in} - {r_target[DATA_W-1], r_target};
  assign w_in_band = (w_err >= -TOL_S) && (w_err <= TOL_S);
  assign w_settle  = w_in_band && (r_run == RUN_W'(HOLD - 1));
  assign w_last    = r_cnt == CNT_W'(MAX_CNT - 1);
`ifdef FIR_SETTLE_PEAK_EN
  logic signed [DATA_W-1:0] r_peak;
  always_ff @(posedge clk) begin
    if (reset) r_peak <= '0;
    else if (r_state != TRACK && start) r_peak <= {1'b1, {(DATA_W-1){1'b0}}};
    else if (r_state == TRACK && clk_enable) r_peak <= (sample_in > r_peak) ? sample_in : r_peak;
  end
  assign peak = r_peak;
`else
  assign peak = '0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= IDLE;
      r_target       <= '0;
      r_cnt          <= '0;
      r_run          <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_settled      <= 1'b0;
      r_timeout      <= 1'b0;
      r_settle_count <= '0;
    end else begin
      unique case (r_state)
        TRACK: begin
          if (clk_enable) begin
            r_cnt <= r_cnt + 1'b1;
            r_run <= w_in_band ? r_run + 1'b1 : '0;
            if (w_settle) begin
              r_settle_count <= r_cnt - CNT_W'(HOLD - 1);
              r_settled      <= 1'b1;
              r_done         <= 1'b1;
              r_busy         <= 1'b0;
              r_state        <= DONE;
            end else if (w_last) begin
              r_settle_count <= CNT_W'(MAX_CNT);
              r_timeout      <= 1'b1;
              r_done         <= 1'b1;
              r_busy         <= 1'b0;
              r_state        <= DONE;
            end
          end
        end
        default: begin
          r_done <= 1'b0;
          if (start) begin
            r_state        <= TRACK;
            r_target       <= target;
            r_cnt          <= '0;
            r_run          <= '0;
            r_settled      <= 1'b0;
            r_timeout      <= 1'b0;
            r_settle_count <= '0;
            r_busy         <= 1'b1;
          end
        end
      endcase
    end
  end
  assign busy         = r_busy;
  assign done         = r_done;
  assign settled      = r_settled;
  assign timeout      = r_timeout;
  assign settle_count = r_settle_count;
endmodule

// File: tb/tb_fir_settle_monitor.sv
// tb_fir_settle_monitor: directed step-response vectors with hand-computed settle results
module tb_fir_settle_monitor;
  logic clk = 1'b0, reset = 1'b0, clk_enable = 1'b0, start = 1'b0;
  logic signed [13:0] target = '0, sample_in = '0, peak;
  logic busy, done, settled, timeout;
  logic [15:0] settle_count;
  logic signed [13:0] seq[$];
  int n_chk = 0, n_fail = 0, cyc;
  fir_settle_monitor dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .start(start),
    .target(target), .sample_in(sample_in), .busy(busy), .done(done),
    .settled(settled), .timeout(timeout), .settle_count(settle_count), .peak(peak)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  function automatic int pk(input int v);
`ifdef FIR_SETTLE_PEAK_EN
    return v;
`else
    return 0;
`endif
  endfunction
  task automatic measure(input logic signed [13:0] tgt, input bit now, input bit toggle, input int budget, output int cycles);
    int idx = 0;
    bit en = 1'b1;
    if (!now) @(negedge clk);
    start = 1'b1; target = tgt; clk_enable = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_done", done, 0);
    check("start_flags", {settled, timeout}, 0);
    check("start_count", settle_count, 0);
    cycles = 0;
    while (!done && cycles < budget) begin
      sample_in = seq[idx < seq.size() ? idx : seq.size() - 1];
      clk_enable = en;
      @(posedge clk);
      if (en) idx++;
      if (toggle) en = !en;
      @(negedge clk);
      cycles++;
    end
    clk_enable = 1'b0;
    check("done_seen", done, 1);
    check("busy_off", busy, 0);
  endtask
  task automatic results(input string tag, input int exp_cyc, input int got_cyc, input bit s, input bit t, input int cnt, input int pv);
    check({tag, "_cycles"}, got_cyc, exp_cyc);
    check({tag, "_settled"}, settled, s);
    check({tag, "_timeout"}, timeout, t);
    check({tag, "_count"}, settle_count, cnt);
    check({tag, "_peak"}, peak, pk(pv));
  endtask
  task automatic held(input string tag, input int cnt);
    @(negedge clk);
    check({tag, "_pulse"}, done, 0);
    check({tag, "_hold"}, settle_count, cnt);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    reset = 1'b1; start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      target = 14'($urandom); sample_in = 14'($urandom); clk_enable = 1'($urandom);
      @(negedge clk);
    end
    check("rst_outs", {busy, done, settled, timeout}, 0);
    check("rst_count", settle_count, 0);
    check("rst_peak", peak, 0);
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    check("rst_idle", busy, 0);
    seq = {14'sd7373};
    measure(14'sd7373, 0, 0, 50, cyc);
    results("imm", 8, cyc, 1, 0, 0, 7373);
    held("imm", 0);
    seq = {};
    for (int i = 0; i < 5; i++) seq.push_back(14'sd0);
    seq.push_back(14'sd7373);
    measure(14'sd7373, 0, 0, 50, cyc);
    results("step", 13, cyc, 1, 0, 5, 7373);
    measure(14'sd7373, 0, 1, 100, cyc);
    results("step_en", 25, cyc, 1, 0, 5, 7373);
    seq = {};
    for (int i = 0; i < 6; i++) seq.push_back(14'sd7389);
    seq.push_back(14'sd7390);
    seq.push_back(14'sd7357);
    measure(14'sd7373, 0, 0, 50, cyc);
    results("edge", 15, cyc, 1, 0, 7, 7390);
    seq = {14'sd7389, 14'sd7389, 14'sd7500, 14'sd7373};
    measure(14'sd7373, 0, 0, 50, cyc);
    results("over", 11, cyc, 1, 0, 3, 7500);
    seq = {14'sd0};
    measure(14'sd7373, 0, 0, 1100, cyc);
    results("tmo", 1000, cyc, 0, 1, 1000, 0);
    seq = {14'sd7373};
    measure(14'sd7373, 1, 0, 50, cyc);
    results("restart", 8, cyc, 1, 0, 0, 7373);
    held("restart", 0);
    @(negedge clk);
    start = 1'b1; target = 14'sd7373;
    @(negedge clk);
    start = 1'b0; sample_in = 14'sd7373; clk_enable = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b1; clk_enable = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check("mid_outs", {busy, done, settled, timeout}, 0);
    check("mid_count", settle_count, 0);
    check("mid_peak", peak, 0);
    measure(14'sd7373, 0, 0, 50, cyc);
    results("after", 8, cyc, 1, 0, 0, 7373);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
